// File: rtl/deser_frame.sv
// rtl/deser_frame.sv - framed serial-to-parallel deserializer with held output word
// Optional even-parity bit per frame when DESER_FRAME_PARITY_EN is defined.
module deser_frame #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             enable,
  input  logic             start,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef DESER_FRAME_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;

  logic [WIDTH-1:0] shifted, first_word, done_word;
  logic             done, done_err;

  always_comb begin
    if (LSB_FIRST) begin
      shifted    = {serial_in, shift_q[WIDTH-1:1]};
      first_word = {serial_in, {(WIDTH-1){1'b0}}};
    end else begin
      shifted    = {shift_q[WIDTH-2:0], serial_in};
      first_word = {{(WIDTH-1){1'b0}}, serial_in};
    end
  end

  // start always wins, including on what would otherwise be the completing bit
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    done      = 1'b0;
    done_err  = 1'b0;
    done_word = shifted;
    if (enable) begin
      if (start) begin
        state_d   = SHIFT;
        shift_d   = first_word;
        bit_cnt_d = CW'(1);
      end else begin
        case (state_q)
          SHIFT: begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (bit_cnt_q == CW'(WIDTH - 1)) begin
`ifdef DESER_FRAME_PARITY_EN
              state_d = PARITY;
`else
              state_d   = IDLE;
              bit_cnt_d = '0;
              done      = 1'b1;
`endif
            end
          end
`ifdef DESER_FRAME_PARITY_EN
          PARITY: begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            done      = 1'b1;
            done_word = shift_q;
            done_err  = ^{shift_q, serial_in};
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = 1'b0;
    if (done) begin
      if (!valid_q || out_ready) begin
        data_d  = done_word;
        ferr_d  = done_err;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = ovr_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_deser_frame.sv
// tb/tb_deser_frame.sv - directed bench for deser_frame, MSB-first and LSB-first instances
// Both instances see the same bit stream; parity steps build only with DESER_FRAME_PARITY_EN.
module tb_deser_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] m_data, l_data;
  logic       m_valid, l_valid, m_busy, l_busy, m_ovr, l_ovr, m_ferr, l_ferr;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  deser_frame #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .enable(enable), .start(start),
    .data_out(m_data), .out_valid(m_valid), .out_ready(out_ready),
    .busy(m_busy), .overrun(m_ovr), .frame_err(m_ferr)
  );

  deser_frame #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .enable(enable), .start(start),
    .data_out(l_data), .out_valid(l_valid), .out_ready(out_ready),
    .busy(l_busy), .overrun(l_ovr), .frame_err(l_ferr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic st);
    serial_in = b;
    start     = st;
    enable    = 1'b1;
    tick();
    enable    = 1'b0;
    start     = 1'b0;
  endtask

  // out_ready takes rdy_done only on the completing cycle
  task automatic send_frame(input logic [7:0] w, input logic rdy_done);
    for (int i = 7; i >= 0; i--) begin
`ifndef DESER_FRAME_PARITY_EN
      if (i == 0) out_ready = rdy_done;
`endif
      send_bit(w[i], i == 7);
    end
`ifdef DESER_FRAME_PARITY_EN
    out_ready = rdy_done;
    send_bit(^w, 1'b0);
`endif
  endtask

  initial begin
    tick();
    tick();
    chk("rst_data", m_data, 8'h00);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_busy", m_busy, 1'b0);
    chk("rst_ovr", m_ovr, 1'b0);
    chk("rst_ferr", m_ferr, 1'b0);
    chk("rst_l_flags", {l_valid, l_busy, l_ovr, l_ferr}, 4'b0000);
    rst = 1'b0;
    out_ready = 1'b1;

    for (int i = 7; i >= 1; i--) send_bit(((8'hA5 >> i) & 8'h01) != 0, i == 7);
    chk("a5_busy_mid", m_busy, 1'b1);
    chk("a5_valid_early", m_valid, 1'b0);
`ifdef DESER_FRAME_PARITY_EN
    send_bit(1'b1, 1'b0);
    chk("a5_valid_before_par", m_valid, 1'b0);
    send_bit(1'b0, 1'b0);
`else
    send_bit(1'b1, 1'b0);
`endif
    chk("a5_valid", m_valid, 1'b1);
    chk("a5_msb", m_data, 8'hA5);
    chk("a5_lsb", l_data, 8'hA5);
    chk("a5_busy_done", m_busy, 1'b0);
    tick();
    chk("a5_consumed", m_valid, 1'b0);
    chk("a5_hold_data", m_data, 8'hA5);

    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    tick(); tick(); tick();
    chk("gap_busy", l_busy, 1'b1);
    chk("gap_valid", l_valid, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
`ifdef DESER_FRAME_PARITY_EN
    send_bit(1'b0, 1'b0);
`endif
    chk("gap_lsb", l_data, 8'hA5);
    chk("gap_msb", m_data, 8'hA5);
    send_frame(8'hC0, 1'b1);
    chk("c0_lsb", l_data, 8'h03);
    chk("c0_msb", m_data, 8'hC0);
    tick();

    out_ready = 1'b0;
    send_frame(8'h11, 1'b0);
    chk("ovr_first", m_data, 8'h11);
    chk("ovr_first_lsb", l_data, 8'h88);
    send_frame(8'h22, 1'b0);
    chk("ovr_pulse", m_ovr, 1'b1);
    chk("ovr_pulse_lsb", l_ovr, 1'b1);
    chk("ovr_kept", m_data, 8'h11);
    chk("ovr_valid", m_valid, 1'b1);
    tick();
    chk("ovr_one_cycle", m_ovr, 1'b0);
    send_frame(8'h22, 1'b1);
    chk("hs_load", m_data, 8'h22);
    chk("hs_load_lsb", l_data, 8'h44);
    chk("hs_valid", m_valid, 1'b1);
    chk("hs_no_ovr", m_ovr, 1'b0);
    tick();
    chk("hs_drain", m_valid, 1'b0);

    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_frame(8'h3C, 1'b1);
    chk("resync_msb", m_data, 8'h3C);
    chk("resync_lsb", l_data, 8'h3C);
    tick();
    chk("resync_single_word", m_valid, 1'b0);

    for (int i = 7; i >= 1; i--) send_bit(1'b0, i == 7);
    send_bit(1'b1, 1'b1);
    chk("startprio_valid", m_valid, 1'b0);
    chk("startprio_busy", m_busy, 1'b1);
    for (int i = 6; i >= 0; i--) send_bit(i == 0, 1'b0);
`ifdef DESER_FRAME_PARITY_EN
    send_bit(1'b0, 1'b0);
`endif
    chk("startprio_msb", m_data, 8'h81);
    chk("startprio_lsb", l_data, 8'h81);
    tick();

    out_ready = 1'b0;
    send_frame(8'h5A, 1'b0);
    chk("pend_valid", m_valid, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_data", m_data, 8'h00);
    chk("midrst_valid", m_valid, 1'b0);
    chk("midrst_busy", m_busy, 1'b0);
    chk("midrst_ovr", m_ovr, 1'b0);
    out_ready = 1'b1;
    send_frame(8'hFF, 1'b1);
    chk("ff_msb", m_data, 8'hFF);
    chk("ff_lsb", l_data, 8'hFF);
    chk("ff_valid", m_valid, 1'b1);
    tick();

`ifdef DESER_FRAME_PARITY_EN
    for (int i = 7; i >= 0; i--) send_bit(((8'h07 >> i) & 8'h01) != 0, i == 7);
    send_bit(1'b1, 1'b0);
    chk("par_ok_data", m_data, 8'h07);
    chk("par_ok_err", m_ferr, 1'b0);
    for (int i = 7; i >= 0; i--) send_bit(((8'h07 >> i) & 8'h01) != 0, i == 7);
    send_bit(1'b0, 1'b0);
    chk("par_bad_data", m_data, 8'h07);
    chk("par_bad_lsb", l_data, 8'hE0);
    chk("par_bad_err", m_ferr, 1'b1);
    chk("par_bad_err_lsb", l_ferr, 1'b1);
`else
    chk("noparity_ferr", m_ferr, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
